// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: controller state encoding
// and the iteration-counter width derivation.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter width needed to count WIDTH shift iterations (0 .. WIDTH-1).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mult_ctrl_fsm.sv
// Controller for the shift-add multiplier: sequences IDLE -> INIT -> WIDTH
// SHIFT cycles -> DONE and exposes registered Moore strobes to the datapath.
module mult_ctrl_fsm
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic init,
  output logic SR,
  output logic done,
  output logic busy,
  output logic last_shift
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;

  // State, iteration count and output strobes; outputs are registered
  // together with the state they decode so they never glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      init  <= 1'b0;
      SR    <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge value of the others, independent of statement order.
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_INIT;
            init  <= 1'b1;
            busy  <= 1'b1;
          end
          SR   <= 1'b0;
          done <= 1'b0;
        end
        ST_INIT: begin
          state <= ST_SHIFT;
          count <= '0;
          init  <= 1'b0;
          SR    <= 1'b1;
          done  <= 1'b0;
          busy  <= 1'b1;
        end
        ST_SHIFT: begin
          count <= count + 1'b1;
          init  <= 1'b0;
          busy  <= 1'b1;
          if (count == LAST_CNT) begin
            state <= ST_DONE;
            SR    <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          init  <= 1'b0;
          SR    <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          init  <= 1'b0;
          SR    <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The final shift edge is the one that also loads the product register.
  assign last_shift = SR && (count == LAST_CNT);

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: M, A, Q and carry datapath driven
// by mult_ctrl_fsm, with a start/done/busy handshake and registered product.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               init,
  output logic               SR
);

  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q_r;
  logic             c_r;
  logic             last_shift;
  logic [WIDTH:0]   sum;
  logic             accept;

  mult_ctrl_fsm #(.WIDTH(WIDTH)) u_ctrl (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .init       (init),
    .SR         (SR),
    .done       (done),
    .busy       (busy),
    .last_shift (last_shift)
  );

  // busy is low only in IDLE, so this is exactly the accept edge.
  assign accept = start && !busy;

  // Partial-product add, one bit wider so the carry lands in C. C is always
  // zero here after INIT or a shift, so including it keeps {C,A} exact.
  assign sum = {c_r, a_r} + (q_r[0] ? {1'b0, m_r} : '0);

  // Operand capture, accumulator clear, add-and-shift, and product load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_r     <= '0;
      a_r     <= '0;
      q_r     <= '0;
      c_r     <= 1'b0;
      product <= '0;
    end else begin
      if (accept) begin
        m_r <= multiplicand;
        q_r <= multiplier;
      end
      if (init) begin
        a_r <= '0;
        c_r <= 1'b0;
      end
      if (SR) begin
        // {C,A,Q} <= {sum,Q} >> 1 with C zero-filled.
        c_r <= 1'b0;
        a_r <= sum[WIDTH:1];
        q_r <= {sum[0], q_r[WIDTH-1:1]};
      end
      // Load the post-shift result on the DONE entry edge.
      if (last_shift) begin
        product <= {sum, q_r[WIDTH-1:1]};
      end
    end
  end

endmodule
